// File: rtl/neurosync_pkg.sv
// neurosync_pkg: shared FSM state codes and timing constants for the neurosync sequencer
package neurosync_pkg;
  localparam int N_RODADAS = 16;
  localparam int T_MOSTRA = 1000;
  localparam int T_FACIL = 5000;
  localparam int T_DIFICIL = 2000;
  localparam int TW = 16;
  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    CONFIG      = 4'd1,
    PREPARA     = 4'd2,
    MOSTRA      = 4'd3,
    ESPERA      = 4'd4,
    REGISTRA    = 4'd5,
    COMPARA     = 4'd6,
    PROX_JOGADA = 4'd7,
    PROX_RODADA = 4'd8,
    FIM_ACERTO  = 4'd9,
    FIM_ERRO    = 4'd10,
    FIM_TIMEOUT = 4'd11
  } estado_t;
endpackage

// File: rtl/neurosync_timer.sv
// neurosync_timer: cycle counter with clear, enable and a terminal flag at limite-1
module neurosync_timer
  import neurosync_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] limite,
  output logic          fim
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !fim) cnt <= cnt + 1'b1;
  assign fim = cnt == limite - 1'b1;
endmodule

// File: rtl/neurosync_seq.sv
// neurosync_seq: control FSM for the neurosync n-back game (rounds, display, play capture, timeouts)
module neurosync_seq
  import neurosync_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       confirma,
  input  logic       nivel,
  input  logic [3:0] botoes,
  input  logic [3:0] seq_dado,
  input  logic       acertou,
  output logic [3:0] rodada,
  output logic       sel_anterior,
  output logic [3:0] jogada,
  output logic       jogada_valid,
  output logic [3:0] leds,
  output logic [1:0] acertos,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);
  estado_t estado, prox;
  logic [3:0] botoes_q;
  logic nivel_l, evento, fim, mais, ultima, limpa, clr;
  logic [TW-1:0] limite;
  assign evento = |botoes && ~|botoes_q;
  assign mais = rodada != 4'd0 && !sel_anterior;
  assign ultima = rodada == 4'(N_RODADAS - 1);
  assign pronto = estado == FIM_ACERTO || estado == FIM_ERRO || estado == FIM_TIMEOUT;
  assign timeout = estado == FIM_TIMEOUT;
  assign limpa = estado == PREPARA || (pronto && jogar);
  assign leds = estado == MOSTRA ? seq_dado : 4'd0;
  assign jogada_valid = estado == REGISTRA;
  assign db_estado = estado;
  // one counter serves both windows: it restarts whenever MOSTRA or ESPERA is (re)entered
  assign clr = !(estado == MOSTRA || estado == ESPERA) || (estado == MOSTRA && fim);
  assign limite = estado == MOSTRA ? TW'(T_MOSTRA) : nivel_l ? TW'(T_DIFICIL) : TW'(T_FACIL);
  neurosync_timer u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .en    (1'b1),
    .limite(limite),
    .fim   (fim)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) estado <= INICIAL;
    else estado <= prox;
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:     prox = jogar ? CONFIG : INICIAL;
      CONFIG:      prox = confirma ? PREPARA : CONFIG;
      PREPARA:     prox = MOSTRA;
      MOSTRA:      prox = fim ? ESPERA : MOSTRA;
      ESPERA:      prox = evento ? REGISTRA : fim ? FIM_TIMEOUT : ESPERA;
      REGISTRA:    prox = COMPARA;
      COMPARA:     prox = acertou ? PROX_JOGADA : FIM_ERRO;
      PROX_JOGADA: prox = mais ? ESPERA : PROX_RODADA;
      PROX_RODADA: prox = ultima ? FIM_ACERTO : MOSTRA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: prox = jogar ? CONFIG : estado;
      default:     prox = INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rodada <= '0;
      acertos <= '0;
      sel_anterior <= 1'b0;
      jogada <= '0;
      nivel_l <= 1'b0;
      botoes_q <= '0;
    end else begin
      botoes_q <= botoes;
      if (estado == CONFIG && confirma) nivel_l <= nivel;
      if (estado == ESPERA && evento) jogada <= botoes;
      if (estado == COMPARA && acertou && acertos != 2'd2) acertos <= acertos + 2'd1;
      if (estado == PROX_JOGADA && mais) sel_anterior <= 1'b1;
      if (estado == PROX_RODADA && !ultima) begin
        rodada <= rodada + 4'd1;
        acertos <= '0;
        sel_anterior <= 1'b0;
      end
      if (limpa) begin
        rodada <= '0;
        acertos <= '0;
        sel_anterior <= 1'b0;
      end
    end
endmodule

// File: tb/tb_neurosync_seq.sv
// tb_neurosync_seq: scoreboard bench for the neurosync sequencer with a ROM/comparator model
module tb_neurosync_seq;
  logic clock = 0, reset = 0, jogar = 0, confirma = 0, nivel = 0, err_force = 0;
  logic [3:0] botoes = 0;
  logic [3:0] seq_dado, rodada, jogada, leds, db_estado;
  logic acertou, sel_anterior, jogada_valid, pronto, timeout;
  logic [1:0] acertos;
  logic [3:0] last_rodada = 0;
  logic [1:0] last_acertos = 0;
  typedef struct {logic [3:0] j; logic s;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  function automatic logic [3:0] rom(input logic [3:0] a);
    case (a[1:0])
      2'd0: rom = 4'b0001;
      2'd1: rom = 4'b0100;
      2'd2: rom = 4'b0010;
      default: rom = 4'b1000;
    endcase
  endfunction
  assign seq_dado = rom(rodada);
  assign acertou = !err_force && jogada == rom(sel_anterior ? rodada - 4'd1 : rodada);
  always @(negedge clock)
    if (db_estado == 4'd8) begin
      last_rodada <= rodada;
      last_acertos <= acertos;
    end
  neurosync_seq dut (
    .clock(clock), .reset(reset), .jogar(jogar), .confirma(confirma), .nivel(nivel),
    .botoes(botoes), .seq_dado(seq_dado), .acertou(acertou), .rodada(rodada),
    .sel_anterior(sel_anterior), .jogada(jogada), .jogada_valid(jogada_valid), .leds(leds),
    .acertos(acertos), .pronto(pronto), .timeout(timeout), .db_estado(db_estado)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_state(input logic [3:0] s, input int bound);
    for (int i = 0; i < bound && db_estado != s; i++) @(negedge clock);
    chk("wait_state", db_estado, s);
  endtask
  task automatic start_game(input logic lvl, input logic early);
    @(negedge clock);
    jogar = 1;
    nivel = lvl;
    confirma = early;
    @(negedge clock);
    chk("config_state", db_estado, 4'd1);
    chk("config_rodada", rodada, 0);
    chk("config_acertos", acertos, 0);
    jogar = 0;
    confirma = 1;
    @(negedge clock);
    chk("prepara_state", db_estado, 4'd2);
    confirma = 0;
    @(negedge clock);
    chk("mostra_state", db_estado, 4'd3);
  endtask
  task automatic press(input logic [3:0] v, input logic sel);
    exp_t e;
    int pulses = 0;
    q.push_back('{j: v, s: sel});
    botoes = v;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (jogada_valid) begin
        pulses++;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("jogada", jogada, e.j);
          chk("sel_anterior", sel_anterior, e.s);
        end
      end
    end
    botoes = 0;
    @(negedge clock);
    chk("valid_pulses", pulses, 1);
    q.delete();
  endtask
  task automatic show(input int r);
    wait_state(4'd3, 2000);
    chk("leds_show", leds, rom(4'(r)));
    wait_state(4'd4, 1100);
    chk("leds_off", leds, 0);
  endtask
  task automatic round(input int r);
    show(r);
    press(rom(4'(r)), 1'b0);
    if (r > 0) press(rom(4'(r - 1)), 1'b1);
    chk("round_rodada", last_rodada, r);
    chk("round_acertos", last_acertos, r == 0 ? 1 : 2);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clock);
    chk("rst_state", db_estado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_leds", leds, 0);
    chk("rst_rodada", rodada, 0);
    reset = 1;
    start_game(1'b0, 1'b0);
    chk("leds_r0", leds, 4'b0001);
    n = 0;
    while (db_estado == 4'd3 && n < 1100) begin
      n++;
      @(negedge clock);
    end
    chk("mostra_len", n, 1000);
    chk("espera_state", db_estado, 4'd4);
    chk("leds_after", leds, 0);
    press(rom(4'd0), 1'b0);
    chk("r0_rodada", last_rodada, 0);
    chk("r0_acertos", last_acertos, 1);
    round(1);
    show(2);
    err_force = 1;
    press(rom(4'd2), 1'b0);
    wait_state(4'd10, 20);
    chk("erro_pronto", pronto, 1);
    chk("erro_timeout", timeout, 0);
    err_force = 0;
    start_game(1'b1, 1'b1);
    wait_state(4'd4, 1100);
    nivel = 0;
    n = 0;
    while (db_estado == 4'd4 && n < 2100) begin
      n++;
      @(negedge clock);
    end
    chk("timeout_len", n, 2000);
    chk("timeout_state", db_estado, 4'd11);
    chk("timeout_pronto", pronto, 1);
    chk("timeout_flag", timeout, 1);
    start_game(1'b0, 1'b0);
    for (int r = 0; r < 16; r++) round(r);
    wait_state(4'd9, 50);
    chk("full_rodada", rodada, 15);
    chk("full_pronto", pronto, 1);
    chk("full_timeout", timeout, 0);
    start_game(1'b0, 1'b0);
    round(0);
    wait_state(4'd3, 50);
    repeat (5) @(negedge clock);
    chk("pre_rst_rodada", rodada, 1);
    #2 reset = 0;
    #1;
    chk("arst_state", db_estado, 0);
    chk("arst_leds", leds, 0);
    chk("arst_pronto", pronto, 0);
    chk("arst_rodada", rodada, 0);
    @(negedge clock);
    reset = 1;
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
